// File: rtl/seg_scan_display.sv
// Four-digit common-anode seven-segment scanner showing one 16-bit page of a per-frame source snapshot.
// Build macro SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits on the lower page.
module seg_scan_display #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned PAGE_FRAMES = 256
) (
    input  logic        disp_clk,
    input  logic        rst,
    input  logic [31:0] buffer,
    input  logic [31:0] ir,
    input  logic [10:0] pc,
    input  logic [31:0] regval,
    input  logic [1:0]  src_sel,
    input  logic        page_sel,
    input  logic        auto_page,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);
    localparam int unsigned PS_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FC_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(SCAN_DIV - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(PAGE_FRAMES - 1);

    logic [PS_W-1:0] presc;
    logic [1:0]      digit;
    logic [FC_W-1:0] frame_cnt;
    logic            auto_bit;
    logic            page;
    logic [31:0]     snap;

    logic            slot_tick_c;
    logic            frame_c;
    logic [31:0]     src_word_c;
    logic [31:0]     snap_d;
    logic            page_d;
    logic [1:0]      digit_d;
    logic [15:0]     half_c;
    logic [3:0]      nib_c;
    logic [6:0]      glyph_c;
    logic            blank_c;

    // Scan timing, source mux and next-state of snapshot/page/digit
    always_comb begin
        slot_tick_c = (presc == PS_LAST);
        frame_c     = slot_tick_c && (digit == 2'd3);
        case (src_sel)
            2'd0:    src_word_c = buffer;
            2'd1:    src_word_c = ir;
            2'd2:    src_word_c = {21'b0, pc};
            default: src_word_c = regval;
        endcase
        snap_d  = frame_c ? src_word_c : snap;
        page_d  = frame_c ? (auto_page ? auto_bit : page_sel) : page;
        digit_d = slot_tick_c ? digit + 2'd1 : digit;
    end

    // Outputs are computed from the next digit/snapshot so a new frame starts on its own data
    always_comb begin
        half_c = page_d ? snap_d[31:16] : snap_d[15:0];
        nib_c  = half_c[{digit_d, 2'b00} +: 4];
        case (nib_c)
            4'h0:    glyph_c = 7'h40;
            4'h1:    glyph_c = 7'h79;
            4'h2:    glyph_c = 7'h24;
            4'h3:    glyph_c = 7'h30;
            4'h4:    glyph_c = 7'h19;
            4'h5:    glyph_c = 7'h12;
            4'h6:    glyph_c = 7'h02;
            4'h7:    glyph_c = 7'h78;
            4'h8:    glyph_c = 7'h00;
            4'h9:    glyph_c = 7'h10;
            4'hA:    glyph_c = 7'h08;
            4'hB:    glyph_c = 7'h03;
            4'hC:    glyph_c = 7'h46;
            4'hD:    glyph_c = 7'h21;
            4'hE:    glyph_c = 7'h06;
            default: glyph_c = 7'h0E;
        endcase
        blank_c = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if (!page_d) begin
            case (digit_d)
                2'd1:    blank_c = (half_c[15:4] == 12'h000);
                2'd2:    blank_c = (half_c[15:8] == 8'h00);
                2'd3:    blank_c = (half_c[15:12] == 4'h0);
                default: blank_c = 1'b0;
            endcase
        end
`endif
    end

    always_ff @(posedge disp_clk or negedge rst) begin
        if (!rst) begin
            presc      <= '0;
            digit      <= 2'd0;
            frame_cnt  <= '0;
            auto_bit   <= 1'b0;
            page       <= 1'b0;
            snap       <= 32'h0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            presc      <= slot_tick_c ? '0 : presc + PS_W'(1);
            digit      <= digit_d;
            snap       <= snap_d;
            page       <= page_d;
            frame_tick <= frame_c;
            // Auto-page counter runs regardless of auto_page so switching modes lands mid-cycle
            if (frame_c) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt <= '0;
                    auto_bit  <= ~auto_bit;
                end else begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end
            end
            if (slot_tick_c) begin
                an  <= ~(4'b0001 << digit_d);
                seg <= blank_c ? 7'b1111111 : glyph_c;
                dp  <= ~(page_d && (digit_d == 2'd3));
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: vector table of source/page settings plus
// reset, tear-free snapshot and auto-page sequences, checked through an expected-digit queue.
module tb_seg_scan_display;
    localparam int unsigned SCAN_DIV    = 4;
    localparam int unsigned PAGE_FRAMES = 2;

    logic        disp_clk = 1'b0;
    logic        rst;
    logic [31:0] buffer, ir, regval;
    logic [10:0] pc;
    logic [1:0]  src_sel;
    logic        page_sel, auto_page;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_tick;

    seg_scan_display #(.SCAN_DIV(SCAN_DIV), .PAGE_FRAMES(PAGE_FRAMES)) dut (
        .disp_clk  (disp_clk),
        .rst       (rst),
        .buffer    (buffer),
        .ir        (ir),
        .pc        (pc),
        .regval    (regval),
        .src_sel   (src_sel),
        .page_sel  (page_sel),
        .auto_page (auto_page),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 disp_clk = ~disp_clk;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] buffer;
        logic [31:0] ir;
        logic [10:0] pc;
        logic [31:0] regval;
        logic        page_sel;
        logic [15:0] exp_half;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    vec_t  vecs[11];
    exp_t  sb[$];
    int    checks = 0;
    int    passed = 0;
    time   last_tick;

    // Active-high gfedcba glyphs; the display wants them inverted
    function automatic logic [6:0] glyph_hi(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        else passed++;
    endtask

    // Queue the four digit slots of a frame showing the given 16-bit half
    task automatic push_frame(input logic [15:0] half, input logic upper);
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            logic [15:0] rest;
            logic blank;
            rest  = half >> (d * 4);
            blank = 1'b0;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            blank = !upper && (d != 0) && (rest == 16'h0);
`endif
            e.an  = ~(4'b0001 << d);
            e.seg = blank ? 7'h7F : ~glyph_hi(rest[3:0]);
            e.dp  = !(upper && d == 3);
            sb.push_back(e);
        end
    endtask

    // Wait for a fresh frame_tick pulse, sampled on falling edges
    task automatic wait_frame(input string name);
        for (int k = 0; k < 64; k++) begin
            @(negedge disp_clk);
            if (frame_tick) return;
        end
        checks++;
        $display("FAIL %s: frame_tick not seen within 64 cycles", name);
    endtask

    // Called on the sample where frame_tick is high; checks digits 0..3 of the new frame
    task automatic check_frame(input string name);
        for (int d = 0; d < 4; d++) begin
            exp_t e;
            if (d > 0) begin
                @(negedge disp_clk);
                if (d == 1) chk({name, "_tick_width"}, 32'(frame_tick), 32'd0);
                repeat (SCAN_DIV - 1) @(negedge disp_clk);
            end
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL %s: scoreboard empty at digit %0d", name, d);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s_d%0d", name, d), 32'({an, seg, dp}), 32'({e.an, e.seg, e.dp}));
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2'd1, 32'hA5A5_0F0F, 32'h8C22_0004, 11'h123, 32'h9999_6666, 1'b0, 16'h0004};
        vecs[1]  = '{2'd1, 32'hA5A5_0F0F, 32'h8C22_0004, 11'h123, 32'h9999_6666, 1'b1, 16'h8C22};
        vecs[2]  = '{2'd2, 32'hA5A5_0F0F, 32'h3C3C_7E7E, 11'h7FF, 32'h9999_6666, 1'b0, 16'h07FF};
        vecs[3]  = '{2'd2, 32'hA5A5_0F0F, 32'h3C3C_7E7E, 11'h7FF, 32'h9999_6666, 1'b1, 16'h0000};
        vecs[4]  = '{2'd0, 32'h0000_00AA, 32'h3C3C_7E7E, 11'h123, 32'h9999_6666, 1'b0, 16'h00AA};
        vecs[5]  = '{2'd3, 32'hA5A5_0F0F, 32'h3C3C_7E7E, 11'h123, 32'h0000_0030, 1'b0, 16'h0030};
        vecs[6]  = '{2'd3, 32'hA5A5_0F0F, 32'h3C3C_7E7E, 11'h123, 32'h0000_0000, 1'b0, 16'h0000};
        vecs[7]  = '{2'd3, 32'hA5A5_0F0F, 32'h3C3C_7E7E, 11'h123, 32'hDEAD_BEEF, 1'b1, 16'hDEAD};
        vecs[8]  = '{2'd0, 32'h1234_5678, 32'h3C3C_7E7E, 11'h123, 32'h9999_6666, 1'b1, 16'h1234};
        vecs[9]  = '{2'd0, 32'h1234_5678, 32'h3C3C_7E7E, 11'h123, 32'h9999_6666, 1'b0, 16'h5678};
        vecs[10] = '{2'd2, 32'hA5A5_0F0F, 32'h3C3C_7E7E, 11'h123, 32'h9999_6666, 1'b0, 16'h0123};

        buffer = 32'hFFFF_FFFF; ir = 32'h0; pc = 11'h0; regval = 32'h0;
        src_sel = 2'd0; page_sel = 1'b0; auto_page = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 chk("reset_init", 32'({an, seg, dp, frame_tick}), 32'({4'b1111, 7'h7F, 1'b1, 1'b0}));
        repeat (2) @(negedge disp_clk);
        rst = 1'b1;

        // Startup: first slot at cycle 4 lights digit 1 with snap=0, first snapshot at cycle 16
        for (int k = 1; k <= 16; k++) begin
            @(negedge disp_clk);
            if (k == 3)  chk("pre_first_slot", 32'({an, seg, dp}), 32'({4'b1111, 7'h7F, 1'b1}));
            if (k == 4)  chk("first_slot", 32'({an, seg, dp}), 32'({4'b1101, 7'h40, 1'b1}));
            if (k == 15) chk("pre_first_snap", 32'(frame_tick), 32'd0);
            if (k == 16) chk("first_snap", 32'(frame_tick), 32'd1);
        end

        for (int i = 0; i < 11; i++) begin
            src_sel = vecs[i].src; buffer = vecs[i].buffer; ir = vecs[i].ir;
            pc = vecs[i].pc; regval = vecs[i].regval; page_sel = vecs[i].page_sel;
            wait_frame($sformatf("vec%0d_wait", i));
            push_frame(vecs[i].exp_half, vecs[i].page_sel);
            check_frame($sformatf("vec%0d", i));
        end

        // Tear-free: buffer changes right after the snapshot, old nibbles must persist
        src_sel = 2'd0; page_sel = 1'b0; buffer = 32'h0000_00AA;
        wait_frame("tear_wait0");
        push_frame(16'h00AA, 1'b0);
        buffer = 32'h0000_0055;
        check_frame("tear_old");
        wait_frame("tear_wait1");
        push_frame(16'h0055, 1'b0);
        check_frame("tear_new");

        // Asynchronous reset mid-scan, then auto-page behaviour from a known counter state
        @(negedge disp_clk);
        #1 rst = 1'b0;
        #1 chk("reset_async", 32'({an, seg, dp, frame_tick}), 32'({4'b1111, 7'h7F, 1'b1, 1'b0}));
        buffer = 32'h1234_5678; src_sel = 2'd0; page_sel = 1'b0; auto_page = 1'b0;
        @(negedge disp_clk);
        rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge disp_clk);
            if (k == 3) chk("rel_pre_slot", 32'(an), 32'(4'b1111));
            if (k == 4) chk("rel_first_slot", 32'(an), 32'(4'b1101));
        end
        for (int f = 1; f <= 2; f++) begin
            wait_frame($sformatf("man_wait%0d", f));
            push_frame(16'h5678, 1'b0);
            check_frame($sformatf("man_frame%0d", f));
        end
        auto_page = 1'b1;
        for (int f = 3; f <= 6; f++) begin
            logic upper;
            upper = (f == 3 || f == 4);
            page_sel = !upper;
            wait_frame($sformatf("auto_wait%0d", f));
            if (f > 3) chk($sformatf("auto_period%0d", f), 32'($time - last_tick), 32'(16 * 10));
            last_tick = $time;
            push_frame(upper ? 16'h1234 : 16'h5678, upper);
            check_frame($sformatf("auto_frame%0d", f));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
